// File: rtl/voice_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : voice_scheduler_pkg
// Description : Shared types and widths for the time-multiplexed voice
//               scheduler (FSM state encoding, LUT phase and sample widths).
// Revision    : 1.0 - initial release
// ============================================================================
package voice_scheduler_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Phase index presented to the shared wave lookup
    localparam int LUT_PHASE_W = 7;

    // Unsigned sample returned by the wave lookup
    localparam int SAMPLE_W    = 8;

endpackage : voice_scheduler_pkg
`default_nettype wire

// File: rtl/voice_regfile.sv
`default_nettype none
// ============================================================================
// Module      : voice_regfile
// Description : Per-voice INC / GATE / ACC storage. One config write port and
//               one indexed read/update port used by the sweep sequencer.
//               A config write to the voice being updated in the same cycle
//               wins: the new INC is stored and a gate-off clears ACC.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_regfile
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int ACC_W      = 16,
    parameter int VW         = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // Configuration write port
    input  logic                   i_wr_en,
    input  logic [VW-1:0]          i_wr_voice,
    input  logic [ACC_W-1:0]       i_wr_inc,
    input  logic                   i_wr_gate,
    // Indexed read / accumulate port
    input  logic                   i_upd_en,
    input  logic [VW-1:0]          i_rd_voice,
    output logic [LUT_PHASE_W-1:0] o_rd_phase,
    output logic                   o_rd_gate
);

    logic [ACC_W-1:0]      r_inc [NUM_VOICES];
    logic [ACC_W-1:0]      r_acc [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate;

    // Phase accumulate on issue, then let a same-cycle config write override
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_inc[i] <= '0;
                r_acc[i] <= '0;
            end
            r_gate <= '0;
        end else begin
            if (i_upd_en) begin
                if (r_gate[i_rd_voice]) begin
                    r_acc[i_rd_voice] <= r_acc[i_rd_voice] + r_inc[i_rd_voice];
                end else begin
                    r_acc[i_rd_voice] <= '0;
                end
            end
            if (i_wr_en) begin
                r_inc[i_wr_voice]  <= i_wr_inc;
                r_gate[i_wr_voice] <= i_wr_gate;
                if (!i_wr_gate) begin
                    r_acc[i_wr_voice] <= '0;
                end
            end
        end
    end

    // Read side reflects the pre-update accumulator of the indexed voice
    assign o_rd_phase = r_acc[i_rd_voice][ACC_W-1 -: LUT_PHASE_W];
    assign o_rd_gate  = r_gate[i_rd_voice];

endmodule : voice_regfile
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voice_scheduler
// Description : Time-multiplexed voice sweep. On each accepted sample strobe
//               every voice's phase is issued to a shared wave lookup, the
//               returned samples of gated voices are summed, and the total is
//               presented on MIX_OUT with a one-cycle MIX_VALID strobe.
//               Optional macro VOICE_SCHED_OVERRUN_EN adds OVERRUN / OVR_CNT
//               reporting of strobes that arrive while a sweep is running.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter  int NUM_VOICES  = 8,
    parameter  int LUT_LATENCY = 2,
    parameter  int ACC_W       = 16,
    localparam int VW          = $clog2(NUM_VOICES),
    localparam int MIX_W       = SAMPLE_W + VW
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   SAMPLE_CE,
    input  logic                   CFG_WE,
    input  logic [VW-1:0]          CFG_VOICE,
    input  logic [ACC_W-1:0]       CFG_INC,
    input  logic                   CFG_GATE,
    output logic                   LUT_CE,
    output logic [LUT_PHASE_W-1:0] LUT_PHASE,
    input  logic [SAMPLE_W-1:0]    LUT_SAMPLE,
    output logic [MIX_W-1:0]       MIX_OUT,
    output logic                   MIX_VALID,
    output logic                   BUSY
`ifdef VOICE_SCHED_OVERRUN_EN
    ,
    output logic                   OVERRUN,
    output logic [7:0]             OVR_CNT
`endif
);

    localparam int DW = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;

    sched_state_t               r_state;
    sched_state_t               w_state_nxt;
    logic [VW-1:0]              r_voice;
    logic [VW-1:0]              w_voice_nxt;
    logic [DW-1:0]              r_drain;
    logic [DW-1:0]              w_drain_nxt;
    logic                       w_issue;
    logic                       w_done;
    logic [LUT_PHASE_W-1:0]     w_rd_phase;
    logic                       w_rd_gate;
    logic [LUT_LATENCY-1:0]     r_dly_vld;
    logic [LUT_LATENCY-1:0]     r_dly_gate;
    logic [MIX_W-1:0]           r_sum;
    logic [MIX_W-1:0]           r_mix;
    logic                       r_mix_valid;

    voice_regfile #(
        .NUM_VOICES (NUM_VOICES),
        .ACC_W      (ACC_W),
        .VW         (VW)
    ) u_regfile (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_wr_en    (CFG_WE),
        .i_wr_voice (CFG_VOICE),
        .i_wr_inc   (CFG_INC),
        .i_wr_gate  (CFG_GATE),
        .i_upd_en   (w_issue),
        .i_rd_voice (r_voice),
        .o_rd_phase (w_rd_phase),
        .o_rd_gate  (w_rd_gate)
    );

    // State, voice index and drain counter registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_voice <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_voice <= w_voice_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Sweep sequencing and lookup request generation
    always_comb begin
        w_state_nxt = r_state;
        w_voice_nxt = r_voice;
        w_drain_nxt = r_drain;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        LUT_CE      = 1'b0;
        LUT_PHASE   = '0;
        case (r_state)
            ST_IDLE: begin
                if (SAMPLE_CE) begin
                    w_state_nxt = ST_ISSUE;
                    w_voice_nxt = '0;
                end
            end
            ST_ISSUE: begin
                w_issue   = 1'b1;
                LUT_CE    = 1'b1;
                LUT_PHASE = w_rd_phase;
                if (r_voice == VW'(NUM_VOICES - 1)) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_voice_nxt = r_voice + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Keep the lookup clocked until the last voice's sample lands
                LUT_CE = 1'b1;
                if (r_drain == DW'(LUT_LATENCY - 1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Issue tags travel alongside the lookup so returning samples can be qualified
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dly_vld  <= '0;
            r_dly_gate <= '0;
        end else begin
            r_dly_vld[0]  <= w_issue;
            r_dly_gate[0] <= w_issue & w_rd_gate;
            for (int i = 1; i < LUT_LATENCY; i++) begin
                r_dly_vld[i]  <= r_dly_vld[i-1];
                r_dly_gate[i] <= r_dly_gate[i-1];
            end
        end
    end

    // Running sum of gated samples; published and cleared in DONE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sum       <= '0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
        end else begin
            r_mix_valid <= w_done;
            if (w_done) begin
                r_mix <= r_sum;
                r_sum <= '0;
            end else if (r_dly_vld[LUT_LATENCY-1] && r_dly_gate[LUT_LATENCY-1]) begin
                r_sum <= r_sum + MIX_W'(LUT_SAMPLE);
            end
        end
    end

    assign MIX_OUT   = r_mix;
    assign MIX_VALID = r_mix_valid;
    assign BUSY      = (r_state != ST_IDLE);

`ifdef VOICE_SCHED_OVERRUN_EN
    logic       r_overrun;
    logic [7:0] r_ovr_cnt;

    // Flag and count strobes that land while a sweep is already running
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else begin
            r_overrun <= SAMPLE_CE & BUSY;
            if (SAMPLE_CE && BUSY && (r_ovr_cnt != 8'hFF)) begin
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
            end
        end
    end

    assign OVERRUN = r_overrun;
    assign OVR_CNT = r_ovr_cnt;
`endif

endmodule : voice_scheduler
`default_nettype wire

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, number of time-multiplexed voices (power of two, 2..16).
REQ-002 SHALL have parameter LUT_LATENCY, default 2, CLK cycles from LUT_PHASE/LUT_CE to matching LUT_SAMPLE.
REQ-003 SHALL have parameter ACC_W, default 16, phase accumulator width; LUT_PHASE = acc[ACC_W-1:ACC_W-7].
REQ-004 SHALL have ports: CLK in 1, single clock; RST_N in 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports: SAMPLE_CE in 1, one-CLK sample-rate strobe; CFG_WE in 1, config write; CFG_VOICE in log2(NUM_VOICES), target voice; CFG_INC in ACC_W, phase increment; CFG_GATE in 1, voice on/off.
REQ-006 SHALL have ports: LUT_CE out 1, clock enable to shared wave lookup; LUT_PHASE out 7, lookup phase; LUT_SAMPLE in 8, lookup result.
REQ-007 SHALL have ports: MIX_OUT out 8+log2(NUM_VOICES), unsigned voice sum; MIX_VALID out 1, one-cycle result strobe; BUSY out 1, sweep in progress.

Function
REQ-008 SHALL hold per voice: INC (ACC_W), GATE (1), ACC (ACC_W).
REQ-009 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-010 IDLE: on SAMPLE_CE=1 SHALL go to ISSUE with voice index 0; else stay.
REQ-011 ISSUE: each cycle SHALL drive LUT_PHASE from ACC[v], LUT_CE=1, update ACC[v] <= ACC[v]+INC[v] mod 2^ACC_W if GATE[v], else ACC[v] <= 0; after v=NUM_VOICES-1 SHALL go to DRAIN.
REQ-012 DRAIN: SHALL keep LUT_CE=1 for exactly LUT_LATENCY cycles, LUT_PHASE=0, then go to DONE.
REQ-013 SHALL carry valid+gate of each issue through a LUT_LATENCY-deep shift register; LUT_SAMPLE SHALL be added to the running sum only when the delayed valid and gate are both 1.
REQ-014 DONE: SHALL register sum into MIX_OUT, pulse MIX_VALID for one cycle, clear running sum, return to IDLE.
REQ-015 With defaults, MIX_VALID SHALL assert exactly 11 CLK cycles after the edge sampling SAMPLE_CE (NUM_VOICES+LUT_LATENCY+1).
REQ-016 BUSY SHALL be 1 in ISSUE, DRAIN, DONE; 0 in IDLE; LUT_CE SHALL be 0 in IDLE and DONE.
REQ-017 SAMPLE_CE while BUSY=1 SHALL be ignored (no restart, no queueing).
REQ-018 CFG_WE SHALL write INC/GATE of CFG_VOICE next edge in any state; CFG_GATE=0 SHALL also clear ACC of that voice.
REQ-019 Config write to the voice issued in the same cycle: issue SHALL use old ACC/INC; the write's clear/INC SHALL win the ACC/INC update.
REQ-020 MIX_OUT SHALL hold its value between MIX_VALID pulses; sum width SHALL never overflow.

Reset
REQ-021 RST_N=0 SHALL asynchronously force IDLE, all ACC/INC/GATE=0, running sum=0, shift register=0, MIX_OUT=0, MIX_VALID=0, BUSY=0, LUT_CE=0, LUT_PHASE=0.
REQ-022 Reset mid-sweep SHALL abandon the sweep with no MIX_VALID pulse; first SAMPLE_CE after release SHALL start a clean sweep.

Configuration
REQ-023 Macro VOICE_SCHED_OVERRUN_EN defined: SHALL add port OVERRUN out 1 (one-cycle pulse when SAMPLE_CE=1 and BUSY=1) and OVR_CNT out 8 (saturating at 255, cleared by reset only).
REQ-024 Macro undefined: OVERRUN/OVR_CNT ports and logic SHALL be absent; REQ-017 behaviour unchanged.

Structure
REQ-025 Shared synth package SHALL hold FSM state enum, LUT phase width (7), sample width (8).
REQ-026 Per-voice INC/GATE/ACC storage SHALL be sub-module voice_regfile (write port + one indexed read/update port); FSM, delay line, accumulator stay in voice_scheduler.

Verification (bench lookup model: returns {PHASE,1'b0}, LUT_LATENCY=2)
REQ-027 Reset then idle 20 cycles -> all outputs 0, LUT_CE never 1.
REQ-028 Voice 0 INC=0x0200 gated, others off, 4 SAMPLE_CEs 20 cycles apart -> MIX_OUT 0,2,4,6; MIX_VALID 11 cycles after each strobe.
REQ-029 All 8 voices INC=0x7E00 gated, 2 strobes -> MIX_OUT 0 then 8*126=1008.
REQ-030 Voice 0 INC=0x8000 gated, 3 strobes -> LUT_PHASE 0,64,0 (wrap); MIX_OUT 0,128,0.
REQ-031 SAMPLE_CE at cycle 5 of a sweep -> single MIX_VALID; with VOICE_SCHED_OVERRUN_EN, OVERRUN pulse, OVR_CNT=1.
REQ-032 RST_N low at ISSUE voice 3, release, strobe -> no stale MIX_VALID; next MIX_OUT=0 with all voices off.
